// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC register with a circular instruction queue, redirect flush and illegal-PC fault
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          IMEM_SIZE   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_instr,
  output logic [31:0] deq_pc,
  output logic        fault
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [31:0]   pc;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   q_pc    [QUEUE_DEPTH];
  logic [31:0]   q_instr [QUEUE_DEPTH];
  logic          push, pop;
  assign imem_addr = pc;
  assign fault     = (pc[1:0] != 2'b00) | (({1'b0, pc} + 33'd3) >= 33'(IMEM_SIZE));
  assign deq_valid = (count != '0) & ~reset;
  assign deq_instr = deq_valid ? q_instr[head] : 32'h0;
  assign deq_pc    = deq_valid ? q_pc[head] : 32'h0;
  assign pop       = deq_valid & deq_ready;
  assign push      = ~redirect_valid & ~fault & ((count < (AW+1)'(QUEUE_DEPTH)) | pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      count <= '0;
      head  <= tail;
    end else begin
      pc    <= push ? pc + 32'd4 : pc;
      tail  <= push ? tail + AW'(1) : tail;
      head  <= pop ? head + AW'(1) : head;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_instr;
    end
  end
endmodule
